// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC, instruction memory fetch, prefetch FIFO, redirect and fault latch
module instruction_fetch_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic [DATA_WIDTH-1:0] imem_data_i,
  input  logic                  imem_valid_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] instr_pc_o,
  output logic                  fetch_fault_o,
  output logic [ADDR_WIDTH-1:0] fault_addr_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic {ST_RUN, ST_FAULT} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] fault_addr_q, fault_addr_d;
  logic [PTR_W-1:0]      rptr_q, rptr_d;
  logic [PTR_W-1:0]      wptr_q, wptr_d;
  logic [PTR_W:0]        count_q, count_d;
  logic [DATA_WIDTH-1:0] data_mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_d [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem_d [FIFO_DEPTH];

  logic pop;
  logic push;
  logic full;

  always_comb begin
    pop        = (count_q != '0) && instr_ready_i;
    full       = (count_q == DEPTH_C);
    // A full FIFO that is popping this cycle frees the slot the fetch will fill.
    imem_req_o = !rst_i && (state_q == ST_RUN) && !redirect_i && (!full || pop);
    push       = imem_req_o && imem_valid_i;

    state_d      = state_q;
    pc_d         = pc_q;
    fault_addr_d = fault_addr_q;
    rptr_d       = rptr_q;
    wptr_d       = wptr_q;
    count_d      = count_q;
    data_mem_d   = data_mem_q;
    pc_mem_d     = pc_mem_q;

    if (redirect_i) begin
      pc_d    = redirect_pc_i;
      count_d = '0;
      rptr_d  = wptr_q;
      state_d = ST_RUN;
    end else begin
      if (push) begin
        data_mem_d[wptr_q] = imem_data_i;
        pc_mem_d[wptr_q]   = pc_q;
        wptr_d             = wptr_q + 1'b1;
        pc_d               = pc_q + ADDR_WIDTH'(4);
      end else if (imem_req_o) begin
        fault_addr_d = pc_q;
        state_d      = ST_FAULT;
      end
      if (pop) begin
        rptr_d = rptr_q + 1'b1;
      end
      count_d = count_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_RUN;
      pc_q         <= RESET_PC;
      fault_addr_q <= '0;
      rptr_q       <= '0;
      wptr_q       <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fault_addr_q <= fault_addr_d;
      rptr_q       <= rptr_d;
      wptr_q       <= wptr_d;
      count_q      <= count_d;
    end
  end

  // Entry storage is qualified by count, so it needs no reset.
  always_ff @(posedge clk_i) begin
    data_mem_q <= data_mem_d;
    pc_mem_q   <= pc_mem_d;
  end

  always_comb begin
    imem_addr_o   = pc_q;
    instr_valid_o = (count_q != '0);
    instr_o       = instr_valid_o ? data_mem_q[rptr_q] : '0;
    instr_pc_o    = instr_valid_o ? pc_mem_q[rptr_q] : '0;
    fetch_fault_o = (state_q == ST_FAULT);
    fault_addr_o  = fault_addr_q;
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed scoreboard bench for instruction_fetch_unit
module tb_instruction_fetch_unit;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        imem_valid;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fault;
  logic [31:0] fault_addr;

  logic        w_req;
  logic [5:0]  w_addr;
  logic [31:0] w_data;
  logic        w_valid_i;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [5:0]  w_pc;
  logic        w_fault;
  logic [5:0]  w_fault_addr;

  logic [31:0] mem [16];
  exp_t        sb [$];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  assign imem_valid = (imem_addr[1:0] == 2'b00) && (imem_addr < 32'd64);
  assign imem_data  = mem[imem_addr[5:2]];
  assign w_valid_i  = 1'b1;
  assign w_data     = {26'h0, w_addr} ^ 32'hCAFE0000;

  instruction_fetch_unit u_dut (
    .clk_i(clk), .rst_i(rst), .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .imem_data_i(imem_data), .imem_valid_i(imem_valid), .redirect_i(redirect),
    .redirect_pc_i(redirect_pc), .instr_valid_o(instr_valid), .instr_ready_i(ready),
    .instr_o(instr), .instr_pc_o(instr_pc), .fetch_fault_o(fault), .fault_addr_o(fault_addr)
  );

  instruction_fetch_unit #(.ADDR_WIDTH(6), .RESET_PC(6'h3C)) u_wrap (
    .clk_i(clk), .rst_i(rst), .imem_req_o(w_req), .imem_addr_o(w_addr),
    .imem_data_i(w_data), .imem_valid_i(w_valid_i), .redirect_i(1'b0),
    .redirect_pc_i(6'h0), .instr_valid_o(w_valid), .instr_ready_i(1'b1),
    .instr_o(w_instr), .instr_pc_o(w_pc), .fetch_fault_o(w_fault), .fault_addr_o(w_fault_addr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pop_now(input string tag);
    exp_t e;
    chk({tag, "_valid"}, 64'(instr_valid), 64'(1));
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 64'(0), 64'(1));
    end else begin
      e = sb.pop_front();
      chk({tag, "_instr"}, 64'(instr), 64'(e.instr));
      chk({tag, "_pc"}, 64'(instr_pc), 64'(e.pc));
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("count_bound", 64'(u_dut.count_q <= 3'd4), 64'(1));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h10000000 + 32'(i);
    mem[0] = 32'h009403b3;
    mem[1] = 32'h40b503b3;
    mem[2] = 32'h02d602b3;
    mem[5] = 32'h016ada33;
    rst = 1'b1; ready = 1'b1; redirect = 1'b0; redirect_pc = '0;

    // 1: back-to-back stream from reset
    step();
    chk("rst_valid", 64'(instr_valid), 64'(0));
    chk("rst_fault", 64'(fault), 64'(0));
    chk("rst_fault_addr", 64'(fault_addr), 64'(0));
    chk("rst_instr", 64'(instr), 64'(0));
    chk("rst_instr_pc", 64'(instr_pc), 64'(0));
    chk("rst_req", 64'(imem_req), 64'(0));
    chk("rst_addr", 64'(imem_addr), 64'(0));
    rst = 1'b0;
    #1;
    chk("t1_req", 64'(imem_req), 64'(1));
    chk("t1_addr", 64'(imem_addr), 64'(0));
    sb.push_back('{32'h009403b3, 32'h0});
    sb.push_back('{32'h40b503b3, 32'h4});
    sb.push_back('{32'h02d602b3, 32'h8});
    for (int i = 0; i < 3; i++) begin
      step();
      pop_now("t1");
    end

    // 2: fill with decode stalled, then drain
    sb.delete();
    rst = 1'b1; ready = 1'b0;
    step();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_fill_req", 64'(imem_req), 64'(1));
      chk("t2_fill_addr", 64'(imem_addr), 64'(4 * i));
      step();
    end
    chk("t2_full_req", 64'(imem_req), 64'(0));
    chk("t2_full_addr", 64'(imem_addr), 64'(16));
    ready = 1'b1;
    #1;
    chk("t2_full_pop_req", 64'(imem_req), 64'(1));
    sb.push_back('{32'h009403b3, 32'h0});
    sb.push_back('{32'h40b503b3, 32'h4});
    sb.push_back('{32'h02d602b3, 32'h8});
    sb.push_back('{32'h10000003, 32'hC});
    sb.push_back('{32'h10000004, 32'h10});
    pop_now("t2");
    for (int i = 0; i < 4; i++) begin
      step();
      pop_now("t2");
    end

    // 3: redirect with entries pending
    sb.delete();
    rst = 1'b1; ready = 1'b0;
    step();
    rst = 1'b0;
    step(); step(); step();
    sb.push_back('{32'h009403b3, 32'h0});
    ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h14;
    #1;
    chk("t3_redir_req", 64'(imem_req), 64'(0));
    pop_now("t3");
    sb.delete();
    step();
    redirect = 1'b0;
    #1;
    chk("t3_flushed", 64'(instr_valid), 64'(0));
    chk("t3_req", 64'(imem_req), 64'(1));
    chk("t3_addr", 64'(imem_addr), 64'(32'h14));
    sb.push_back('{32'h016ada33, 32'h14});
    step();
    pop_now("t3");

    // 4: unaligned redirect faults, redirect clears it
    redirect = 1'b1; redirect_pc = 32'h2;
    step();
    redirect = 1'b0;
    #1;
    chk("t4_addr", 64'(imem_addr), 64'(2));
    chk("t4_pre_fault", 64'(fault), 64'(0));
    step();
    chk("t4_fault", 64'(fault), 64'(1));
    chk("t4_fault_addr", 64'(fault_addr), 64'(2));
    chk("t4_req_off", 64'(imem_req), 64'(0));
    chk("t4_valid", 64'(instr_valid), 64'(0));
    step();
    chk("t4_req_stays_off", 64'(imem_req), 64'(0));
    redirect = 1'b1; redirect_pc = 32'h0;
    #1;
    chk("t4_fault_held", 64'(fault), 64'(1));
    step();
    redirect = 1'b0;
    #1;
    chk("t4_cleared", 64'(fault), 64'(0));
    chk("t4_fault_addr_kept", 64'(fault_addr), 64'(2));
    chk("t4_resume_req", 64'(imem_req), 64'(1));
    sb.push_back('{32'h009403b3, 32'h0});
    step();
    pop_now("t4");

    // 5: PC wraps at the top of a 6-bit address space
    sb.delete();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("t5_req", 64'(w_req), 64'(1));
    chk("t5_addr", 64'(w_addr), 64'(6'h3C));
    for (int i = 0; i < 3; i++) begin
      logic [5:0] epc;
      epc = (i == 0) ? 6'h3C : 6'(4 * (i - 1));
      step();
      chk("t5_valid", 64'(w_valid), 64'(1));
      chk("t5_pc", 64'(w_pc), 64'(epc));
      chk("t5_instr", 64'(w_instr), 64'({26'h0, epc} ^ 32'hCAFE0000));
    end

    // 6: reset with entries buffered and a fault latched
    ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h34;
    step();
    redirect = 1'b0;
    step(); step(); step(); step();
    chk("t6_fault", 64'(fault), 64'(1));
    chk("t6_fault_addr", 64'(fault_addr), 64'(32'h40));
    chk("t6_valid", 64'(instr_valid), 64'(1));
    rst = 1'b1;
    #1;
    chk("t6_rst_req", 64'(imem_req), 64'(0));
    step();
    chk("t6_valid_cleared", 64'(instr_valid), 64'(0));
    chk("t6_fault_cleared", 64'(fault), 64'(0));
    chk("t6_fault_addr_cleared", 64'(fault_addr), 64'(0));
    chk("t6_addr", 64'(imem_addr), 64'(0));
    chk("t6_instr", 64'(instr), 64'(0));
    rst = 1'b0;
    #1;
    chk("t6_run_req", 64'(imem_req), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
